// File: rtl/xor_frame_checksum.sv
// XOR frame checksum: folds WIDTH-bit words per frame, emits checksum + count.
// Optional out_parity port enabled by XOR_CKSUM_PARITY_EN.
module xor_frame_checksum #(
  parameter  int WIDTH     = 8,
  parameter  int FRAME_LEN = 16,
  localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count
`ifdef XOR_CKSUM_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] fold;
  logic             accept;
  logic             closing;
`ifdef XOR_CKSUM_PARITY_EN
  logic             par_q, par_d;
`endif

  assign in_ready  = (state_q == ACC);
  assign out_valid = (state_q == HOLD);
  assign out_data  = data_q;
  assign out_count = count_q;
`ifdef XOR_CKSUM_PARITY_EN
  assign out_parity = par_q;
`endif

  assign accept  = in_valid && in_ready;
  assign closing = in_last || (cnt_q == LAST_CNT);
  assign fold    = acc_q ^ in_data;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    count_d = count_q;
`ifdef XOR_CKSUM_PARITY_EN
    par_d   = par_q;
`endif
    if (clr) begin
      // clear wins over every handshake; the presented word is dropped
      state_d = ACC;
      acc_d   = '0;
      cnt_d   = '0;
      data_d  = '0;
      count_d = '0;
`ifdef XOR_CKSUM_PARITY_EN
      par_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        ACC: begin
          if (accept) begin
            if (closing) begin
              state_d = HOLD;
              data_d  = fold;
              count_d = cnt_q + 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
`ifdef XOR_CKSUM_PARITY_EN
              par_d   = ^fold;
`endif
            end else begin
              acc_d = fold;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) state_d = ACC;
        end
        default: state_d = ACC;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

`ifdef XOR_CKSUM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) par_q <= 1'b0;
    else        par_q <= par_d;
  end
`endif

endmodule

// File: tb/tb_xor_frame_checksum.sv
// Self-checking bench for xor_frame_checksum (WIDTH=8, FRAME_LEN=4).
// Reference model keeps the open frame as a queue of words.
module tb_xor_frame_checksum;

  localparam int W  = 8;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_data = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic [CW-1:0] out_count;
`ifdef XOR_CKSUM_PARITY_EN
  logic          out_parity;
`endif

  int checks = 0;
  int errors = 0;

  logic [W-1:0] frame_q[$];
  logic         m_valid = 1'b0;
  logic [W-1:0] m_data  = '0;
  int           m_count = 0;

  xor_frame_checksum #(
    .WIDTH    (W),
    .FRAME_LEN(FL)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count)
`ifdef XOR_CKSUM_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] xor_all();
    logic [W-1:0] x = '0;
    foreach (frame_q[i]) x = x ^ frame_q[i];
    return x;
  endfunction

  task automatic model_reset();
    frame_q.delete();
    m_valid = 1'b0;
    m_data  = '0;
    m_count = 0;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(!m_valid));
    chk({tag, ".out_data"}, 32'(out_data), 32'(m_data));
    chk({tag, ".out_count"}, 32'(out_count), 32'(m_count));
`ifdef XOR_CKSUM_PARITY_EN
    chk({tag, ".out_parity"}, 32'(out_parity), 32'(^m_data));
`endif
  endtask

  // drive one cycle, advance the model, check after the edge
  task automatic cycle(input string tag, input logic v, input logic [W-1:0] d,
                       input logic l, input logic r, input logic c);
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    clr       = c;
    if (c) begin
      model_reset();
    end else if (m_valid) begin
      if (r) m_valid = 1'b0;
    end else if (v) begin
      frame_q.push_back(d);
      if (l || frame_q.size() == FL) begin
        m_data  = xor_all();
        m_count = frame_q.size();
        m_valid = 1'b1;
        frame_q.delete();
      end
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    clr       = 1'b0;
  endtask

  logic [W-1:0] rd;

  initial begin
    // reset state
    #12;
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready", 32'(in_ready), 32'd1);

    // full frame with out_ready high
    cycle("f1w0", 1, 8'h01, 0, 1, 0);
    cycle("f1w1", 1, 8'h02, 0, 1, 0);
    cycle("f1w2", 1, 8'h04, 0, 1, 0);
    cycle("f1w3", 1, 8'h08, 0, 1, 0);
    chk("f1.data", 32'(out_data), 32'h0F);
    chk("f1.count", 32'(out_count), 32'd4);
    chk("f1.in_ready", 32'(in_ready), 32'd0);
    cycle("f1hold", 1, 8'hAA, 0, 1, 0);
    chk("f1.drop", 32'(out_valid), 32'd0);

    // short frame via in_last, then a full frame
    cycle("f2w0", 1, 8'hAA, 0, 1, 0);
    cycle("f2w1", 1, 8'h55, 1, 1, 0);
    chk("f2.data", 32'(out_data), 32'hFF);
    chk("f2.count", 32'(out_count), 32'd2);
    cycle("f2hold", 0, 8'h00, 0, 1, 0);
    cycle("f3w0", 1, 8'h11, 0, 1, 0);
    cycle("f3w1", 1, 8'h22, 0, 1, 0);
    cycle("f3w2", 1, 8'h44, 0, 1, 0);
    cycle("f3w3", 1, 8'h88, 1, 1, 0);
    chk("f3.data", 32'(out_data), 32'hFF);
    chk("f3.count", 32'(out_count), 32'd4);
    cycle("f3hold", 0, 8'h00, 0, 1, 0);

    // backpressure: hold for five cycles with input pending
    cycle("bpw0", 1, 8'h0C, 0, 0, 0);
    cycle("bpw1", 1, 8'h30, 1, 0, 0);
    for (int i = 0; i < 5; i++) cycle("bphold", 1, 8'h77, 0, 0, 0);
    chk("bp.data", 32'(out_data), 32'h3C);
    cycle("bprel", 1, 8'h77, 0, 1, 0);
    cycle("bpres", 1, 8'h77, 0, 1, 0);
    chk("bp.resume", 32'(dut.cnt_q), 32'd1);

    // asynchronous reset mid-frame
    cycle("arw0", 1, 8'h05, 1, 1, 0);
    cycle("arhold", 0, 8'h00, 0, 1, 0);
    cycle("arw1", 1, 8'h06, 0, 1, 0);
    cycle("arw2", 1, 8'h07, 0, 1, 0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    idle_inputs();
    check_outputs("arst");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("ar1w0", 1, 8'h10, 0, 1, 0);
    cycle("ar1w1", 1, 8'h20, 0, 1, 0);
    cycle("ar1w2", 1, 8'h40, 0, 1, 0);
    cycle("ar1w3", 1, 8'h80, 0, 1, 0);
    chk("ar.data", 32'(out_data), 32'hF0);
    chk("ar.count", 32'(out_count), 32'd4);
    cycle("arhold2", 0, 8'h00, 0, 1, 0);

    // clr drops its word and the partial frame
    cycle("clw0", 1, 8'h3C, 0, 1, 0);
    cycle("clclr", 1, 8'hFF, 0, 1, 1);
    for (int i = 0; i < 4; i++) cycle("clf", 1, 8'h01, 0, 1, 0);
    chk("cl.data", 32'(out_data), 32'h00);
    chk("cl.count", 32'(out_count), 32'd4);
    cycle("clhold", 0, 8'h00, 0, 0, 0);
    cycle("clinhold", 0, 8'h00, 0, 0, 1);

`ifdef XOR_CKSUM_PARITY_EN
    cycle("p1w0", 1, 8'h01, 0, 1, 0);
    cycle("p1w1", 1, 8'h02, 0, 1, 0);
    cycle("p1w2", 1, 8'h04, 0, 1, 0);
    cycle("p1w3", 1, 8'h08, 0, 1, 0);
    chk("p1.parity", 32'(out_parity), 32'd0);
    cycle("p1hold", 0, 8'h00, 0, 1, 0);
    cycle("p2w0", 1, 8'h01, 0, 1, 0);
    cycle("p2w1", 1, 8'h02, 0, 1, 0);
    cycle("p2w2", 1, 8'h04, 1, 1, 0);
    chk("p2.data", 32'(out_data), 32'h07);
    chk("p2.parity", 32'(out_parity), 32'd1);
    cycle("p2hold", 0, 8'h00, 0, 1, 0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      rd = 8'($urandom);
      cycle("rand",
            logic'($urandom_range(0, 3) != 0),
            rd,
            logic'($urandom_range(0, 5) == 0),
            logic'($urandom_range(0, 2) != 0),
            logic'($urandom_range(0, 40) == 0));
    end

    idle_inputs();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
